// File: rtl/pif_regbank.sv
// ---------------------------------------------------------------------------
// pif_regbank
//
// Register bank that sits directly behind the wishbone/I2C slave front end.
// The front end delivers register values as a stream of narrow chunks
// (D_BITS each, NCHUNK per register, lowest chunk first). This block collects
// the low chunks into a staging buffer. When the last chunk arrives, it commits
// the whole register in one step, so fabric logic never sees a half-written
// control word.
//
// Reads are served from a snapshot of the addressed register. The snapshot is
// taken when the address is loaded and again each time a full read pass wraps.
// A multi-chunk status value read over I2C is therefore always coherent, even
// when the fabric keeps changing it.
//
// Ports
//   xclk       system clock
//   rst        asynchronous, active-high reset
//   i_addr     register address from the front end
//   i_addr_ld  1-cycle pulse: a new address has been received
//   i_wr       1-cycle pulse: write one chunk
//   i_wr_data  chunk payload for i_wr
//   i_wr_sub   chunk index for i_wr (last index commits the register)
//   i_rd_sub   chunk index presented on o_xo
//   i_rd_done  1-cycle pulse: the o_xo byte has been sent
//   i_stat     fabric status inputs, slice n used when register n is read-only
//   o_xo       registered read byte (chunk zero-extended to 8 bits)
//   o_ctrl     read/write register contents, slice n = register n
//   o_commit   1-cycle pulse per register, the cycle after it was updated
//   o_err      sticky error: commit to a read-only/unimplemented register or
//              an illegal chunk index; cleared by the next address load
// ---------------------------------------------------------------------------
module pif_regbank #(
  parameter int              XA_BITS  = 4,
  parameter int              SUB_BITS = 2,
  parameter int              NCHUNK   = 4,
  parameter int              D_BITS   = 6,
  parameter int              NREG     = 8,
  parameter logic [NREG-1:0] RO_MASK  = 8'hF0,
  localparam int             REG_W    = D_BITS * NCHUNK
) (
  input  logic                  xclk,
  input  logic                  rst,
  input  logic [XA_BITS-1:0]    i_addr,
  input  logic                  i_addr_ld,
  input  logic                  i_wr,
  input  logic [D_BITS-1:0]     i_wr_data,
  input  logic [SUB_BITS-1:0]   i_wr_sub,
  input  logic [SUB_BITS-1:0]   i_rd_sub,
  input  logic                  i_rd_done,
  input  logic [NREG*REG_W-1:0] i_stat,
  output logic [7:0]            o_xo,
  output logic [NREG*REG_W-1:0] o_ctrl,
  output logic [NREG-1:0]       o_commit,
  output logic                  o_err
);

  // The staging buffer only holds the low chunks. The top chunk is taken
  // straight from i_wr_data on the commit cycle.
  localparam int STG_W = D_BITS * (NCHUNK - 1);

  // Architectural state
  logic [XA_BITS-1:0]    addr_q,   addr_d;
  logic [STG_W-1:0]      stg_q,    stg_d;
  logic [REG_W-1:0]      snap_q,   snap_d;
  logic [NREG*REG_W-1:0] ctrl_q,   ctrl_d;
  logic [NREG-1:0]       commit_q, commit_d;
  logic                  err_q,    err_d;
  logic [7:0]            xo_q,     xo_d;

  // Decoded helpers
  logic [NREG-1:0]       ldSel;
  logic [NREG-1:0]       curSel;
  logic [REG_W-1:0]      srcLoad;
  logic [REG_W-1:0]      srcCur;
  logic                  curRw;
  logic [NCHUNK-2:0]     wrStgSel;
  logic                  wrSubLast;
  logic                  wrSubValid;
  logic                  rdSubLast;
  logic                  unusedStat;

  // Read/write registers never look at their status slice. This reduction
  // only marks those bits as deliberately ignored.
  assign unusedStat = ^i_stat;

  // Decode the incoming address and the held address one-hot over the
  // implemented registers. An address at or beyond NREG decodes to all
  // zeros, and that is what makes it unimplemented everywhere below.
  always_comb begin
    ldSel  = '0;
    curSel = '0;
    for (int n = 0; n < NREG; n++) begin
      ldSel[n]  = (i_addr == XA_BITS'(n));
      curSel[n] = (addr_q == XA_BITS'(n));
    end
  end

  // Snapshot source for a register. Read/write registers return their current
  // control value and read-only registers return the live status slice.
  // Unimplemented addresses read as zero. srcCur reads ctrl_q, the value held
  // before any commit in this cycle. A commit and a read wrap on the same
  // register in one cycle therefore snapshot the old value.
  always_comb begin
    srcLoad = '0;
    srcCur  = '0;
    curRw   = 1'b0;
    for (int n = 0; n < NREG; n++) begin
      if (ldSel[n]) begin
        srcLoad = RO_MASK[n] ? i_stat[n*REG_W +: REG_W] : ctrl_q[n*REG_W +: REG_W];
      end
      if (curSel[n]) begin
        srcCur = RO_MASK[n] ? i_stat[n*REG_W +: REG_W] : ctrl_q[n*REG_W +: REG_W];
        curRw  = !RO_MASK[n];
      end
    end
  end

  // Classify the chunk indices. The index can be one of the staged low
  // chunks, the last (committing) chunk, or out of range, which can only
  // happen when NCHUNK < 2**SUB_BITS.
  always_comb begin
    wrStgSel   = '0;
    wrSubLast  = (i_wr_sub == SUB_BITS'(NCHUNK - 1));
    wrSubValid = wrSubLast;
    for (int c = 0; c < NCHUNK - 1; c++) begin
      wrStgSel[c] = (i_wr_sub == SUB_BITS'(c));
      wrSubValid  = wrSubValid | wrStgSel[c];
    end
    rdSubLast = (i_rd_sub == SUB_BITS'(NCHUNK - 1));
  end

  // Main next-state logic. An address load wins outright: it restarts
  // staging, clears the error flag and re-snapshots. Any write or read-done
  // arriving in the same cycle is dropped. Otherwise a write either stages a
  // low chunk or, on the last chunk, commits the whole register in one cycle.
  always_comb begin
    addr_d   = addr_q;
    stg_d    = stg_q;
    snap_d   = snap_q;
    ctrl_d   = ctrl_q;
    commit_d = '0;
    err_d    = err_q;

    if (i_addr_ld) begin
      addr_d = i_addr;
      stg_d  = '0;
      err_d  = 1'b0;
      snap_d = srcLoad;
    end else begin
      if (i_wr) begin
        if (!wrSubValid) begin
          err_d = 1'b1;
        end else if (wrSubLast) begin
          if (curRw) begin
            for (int n = 0; n < NREG; n++) begin
              if (curSel[n]) begin
                ctrl_d[n*REG_W +: REG_W] = {i_wr_data, stg_q};
                commit_d[n]              = 1'b1;
              end
            end
          end else begin
            err_d = 1'b1;
          end
        end else begin
          for (int c = 0; c < NCHUNK - 1; c++) begin
            if (wrStgSel[c]) begin
              stg_d[c*D_BITS +: D_BITS] = i_wr_data;
            end
          end
        end
      end

      // When the front end finishes the last chunk of a pass, take a fresh
      // snapshot so the next pass sees up-to-date data.
      if (i_rd_done && rdSubLast) begin
        snap_d = srcCur;
      end
    end
  end

  // Read byte: the selected snapshot chunk, zero-extended. It reads snap_q,
  // so a new snapshot or chunk index shows up one cycle later.
  always_comb begin
    xo_d = '0;
    for (int c = 0; c < NCHUNK; c++) begin
      if (i_rd_sub == SUB_BITS'(c)) begin
        xo_d = 8'(snap_q[c*D_BITS +: D_BITS]);
      end
    end
  end

  // State registers. Reset discards any partial staging and suppresses any
  // pending commit pulse.
  always_ff @(posedge xclk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      stg_q    <= '0;
      snap_q   <= '0;
      ctrl_q   <= '0;
      commit_q <= '0;
      err_q    <= 1'b0;
      xo_q     <= '0;
    end else begin
      addr_q   <= addr_d;
      stg_q    <= stg_d;
      snap_q   <= snap_d;
      ctrl_q   <= ctrl_d;
      commit_q <= commit_d;
      err_q    <= err_d;
      xo_q     <= xo_d;
    end
  end

  assign o_xo     = xo_q;
  assign o_ctrl   = ctrl_q;
  assign o_commit = commit_q;
  assign o_err    = err_q;

endmodule
